// File: rtl/shift_add_sequencer.sv
// ============================================================================
// Module   : shift_add_sequencer
// Brief    : Control/accumulate stage of a sequential shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_sequencer #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WIDTH-1:0]           multiplier,
    input  logic [WIDTH-1:0]           mcand_sh,
    output logic                       shift,
    output logic                       add_shift,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           product,
    output logic [$clog2(WIDTH):0]     iter
);

    localparam int                  c_ITER_W    = $clog2(WIDTH) + 1;
    localparam logic [c_ITER_W-1:0] c_LAST_ITER = c_ITER_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_acc;
    logic [WIDTH-1:0]    w_acc_nxt;
    logic [WIDTH-1:0]    r_mreg;
    logic [WIDTH-1:0]    w_mreg_nxt;
    logic [WIDTH-1:0]    w_mreg_sh;
    logic [c_ITER_W-1:0] r_iter;
    logic [c_ITER_W-1:0] w_iter_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_mreg  <= '0;
            r_iter  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_mreg  <= w_mreg_nxt;
            r_iter  <= w_iter_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_mreg_nxt  = r_mreg;
        w_iter_nxt  = r_iter;
        w_mreg_sh   = r_mreg >> 1;
        shift       = 1'b0;
        add_shift   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mreg_nxt  = multiplier;
                    w_acc_nxt   = '0;
                    w_iter_nxt  = '0;
                    // A zero multiplier has no iterations to run at all.
                    w_state_nxt = (EARLY_EXIT && (multiplier == '0)) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy       = 1'b1;
                add_shift  = r_mreg[0];
                shift      = ~r_mreg[0];
                w_acc_nxt  = r_acc + (r_mreg[0] ? mcand_sh : '0);
                w_mreg_nxt = w_mreg_sh;
                w_iter_nxt = r_iter + 1'b1;
                if ((r_iter == c_LAST_ITER) || (EARLY_EXIT && (w_mreg_sh == '0))) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign product = r_acc;
    assign iter    = r_iter;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_sequencer.sv
// ============================================================================
// Module   : tb_shift_add_sequencer
// Brief    : Scoreboard bench for shift_add_sequencer (EARLY_EXIT=1 and 0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_add_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] multiplier = '0;
    logic [W-1:0] mcand_sh = '0;
    logic [W-1:0] tb_mcand = '0;
    logic         shift, add_shift, busy, done;
    logic [W-1:0] product;
    logic [5:0]   iter;

    logic         start0 = 1'b0;
    logic [W-1:0] mult0 = '0;
    logic [W-1:0] sh0 = '0;
    logic [W-1:0] mcand0 = '0;
    logic         shift0, add0, busy0, done0;
    logic [W-1:0] product0;
    logic [5:0]   iter0;

    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [W-1:0] sb[$];

    always #5 clk = ~clk;

    shift_add_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .multiplier(multiplier),
        .mcand_sh(mcand_sh), .shift(shift), .add_shift(add_shift), .busy(busy),
        .done(done), .product(product), .iter(iter)
    );

    shift_add_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .multiplier(mult0),
        .mcand_sh(sh0), .shift(shift0), .add_shift(add0), .busy(busy0),
        .done(done0), .product(product0), .iter(iter0)
    );

    // Left-shifter models: hold the multiplicand until iterations shift it.
    always @(posedge clk) begin
        mcand_sh <= (shift | add_shift) ? (mcand_sh << 1) : tb_mcand;
        sh0      <= (shift0 | add0) ? (sh0 << 1) : mcand0;
    end

    task automatic run_op(input logic [W-1:0] mult, input logic [W-1:0] mc, input bit hold,
                          output int done_at, output int n_add, output int n_shift,
                          output int n_busy, output int n_bad, output logic [63:0] seq,
                          output logic [W-1:0] got, output logic [W-1:0] exp);
        int c;
        done_at = -1; n_add = 0; n_shift = 0; n_busy = 0; n_bad = 0; seq = '0;
        start      = 1'b1;
        multiplier = mult;
        tb_mcand   = mc;
        sb.push_back(mult * mc);
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        c = 1;
        while (!done && c < 200) begin
            if (busy) n_busy++;
            if (busy && (shift == add_shift)) n_bad++;
            if (!busy && (shift | add_shift)) n_bad++;
            if (add_shift) n_add++;
            if (shift) n_shift++;
            if (c <= 64) seq[c-1] = add_shift;
            @(posedge clk); #1;
            c++;
        end
        if (done) done_at = c;
        got = product;
        exp = sb.pop_front();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, shift, add_shift} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, shift, add_shift});
        end
        n_cmp++;
        if (product !== '0 || iter !== '0) begin
            n_fail++; $display("FAIL reset_regs: product %h iter %0d want 0/0", product, iter);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int da, na, ns, nb, nbad;
        logic [63:0] seq;
        logic [W-1:0] got, exp;
        run_op(32'd5, 32'd6, 1'b0, da, na, ns, nb, nbad, seq, got, exp);
        n_cmp++;
        if (da !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", da); end
        n_cmp++;
        if (seq[2:0] !== 3'b101 || ns !== 1 || nbad !== 0) begin
            n_fail++; $display("FAIL basic_seq: seq %b shifts %0d bad %0d want 101/1/0", seq[2:0], ns, nbad);
        end
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL basic_product: got %0d want %0d", got, exp); end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || product !== 32'd30) begin
            n_fail++; $display("FAIL basic_hold: done %b product %0d want 0/30", done, product);
        end
    endtask

    task automatic test_zero();
        int da, na, ns, nb, nbad;
        logic [63:0] seq;
        logic [W-1:0] got, exp;
        run_op(32'd0, 32'h1234, 1'b0, da, na, ns, nb, nbad, seq, got, exp);
        n_cmp++;
        if (da !== 1 || (na + ns) !== 0) begin
            n_fail++; $display("FAIL zero_ee: done_at %0d iters %0d want 1/0", da, na + ns);
        end
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL zero_product: got %h want %h", got, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_no_early_exit();
        int c, ns, na;
        ns = 0; na = 0;
        start0 = 1'b1; mult0 = '0; mcand0 = 32'd5;
        @(posedge clk); #1;
        start0 = 1'b0;
        c = 1;
        while (!done0 && c < 200) begin
            if (shift0) ns++;
            if (add0) na++;
            @(posedge clk); #1;
            c++;
        end
        n_cmp++;
        if (!done0 || c !== 33 || ns !== 32 || na !== 0) begin
            n_fail++; $display("FAIL zero_no_ee: done_at %0d shifts %0d adds %0d want 33/32/0", c, ns, na);
        end
        n_cmp++;
        if (product0 !== '0) begin n_fail++; $display("FAIL zero_no_ee_product: got %h want 0", product0); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        int da, na, ns, nb, nbad;
        logic [63:0] seq;
        logic [W-1:0] got, exp;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, da, na, ns, nb, nbad, seq, got, exp);
        n_cmp++;
        if (da !== 33 || na !== 32) begin
            n_fail++; $display("FAIL overflow_iters: done_at %0d adds %0d want 33/32", da, na);
        end
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL overflow_product: got %h want %h", got, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_while_busy();
        int da, na, ns, nb, nbad;
        logic [63:0] seq;
        logic [W-1:0] got, exp;
        run_op(32'h8000_0000, 32'd3, 1'b1, da, na, ns, nb, nbad, seq, got, exp);
        start = 1'b0;
        n_cmp++;
        if (nb !== 32 || da !== 33 || nbad !== 0) begin
            n_fail++; $display("FAIL busy_window: busy %0d done_at %0d bad %0d want 32/33/0", nb, da, nbad);
        end
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL busy_product: got %h want %h", got, exp); end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_single_done: done %b busy %b want 0/0", done, busy);
        end
    endtask

    task automatic test_reset_mid();
        int c, da, na, ns, nb, nbad;
        logic [63:0] seq;
        logic [W-1:0] got, exp;
        start = 1'b1; multiplier = 32'h8000_0000; tb_mcand = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (iter !== 6'd10 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        n_cmp++;
        if (busy !== 1'b1 || iter !== 6'd10) begin
            n_fail++; $display("FAIL mid_reach: busy %b iter %0d want 1/10", busy, iter);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || iter !== '0) begin
            n_fail++; $display("FAIL mid_reset: busy %b done %b product %h iter %0d want 0/0/0/0",
                               busy, done, product, iter);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mid_idle: busy %b done %b want 0/0", busy, done);
        end
        run_op(32'd3, 32'd7, 1'b0, da, na, ns, nb, nbad, seq, got, exp);
        n_cmp++;
        if (got !== exp || da !== 3) begin
            n_fail++; $display("FAIL mid_restart: product %0d done_at %0d want %0d/3", got, da, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int da, na, ns, nb, nbad;
        logic [63:0] seq;
        logic [W-1:0] got, exp;
        run_op(32'd3, 32'd9, 1'b1, da, na, ns, nb, nbad, seq, got, exp);
        n_cmp++;
        if (got !== exp || da !== 3) begin
            n_fail++; $display("FAIL b2b_first: product %0d done_at %0d want %0d/3", got, da, exp);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd27) begin
            n_fail++; $display("FAIL b2b_idle: busy %b done %b product %0d want 0/0/27", busy, done, product);
        end
        run_op(32'd2, 32'd9, 1'b1, da, na, ns, nb, nbad, seq, got, exp);
        start = 1'b0;
        n_cmp++;
        if (got !== exp || da !== 3) begin
            n_fail++; $display("FAIL b2b_second: product %0d done_at %0d want %0d/3", got, da, exp);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_no_early_exit();
        test_overflow();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_add_sequencer.md
Name: shift_add_sequencer

Overview:
- Control-and-accumulate stage of the sequential shift-add multiplier. Sits directly upstream of the left shifter and consumes its output.
- On each iteration it inspects one multiplier bit, least significant first. It then issues exactly one of shift / add_shift to the left shifter.
- On add_shift it adds the shifted multiplicand returned by the shifter into a product accumulator.
- It owns the start/busy/done handshake for one multiplication.

Parameters:
- WIDTH, 32: operand, shifted-multiplicand and product width. Product is (multiplicand*multiplier) mod 2^WIDTH.
- EARLY_EXIT, 1: 1 = stop once the remaining multiplier bits are all zero; 0 = always run WIDTH iterations.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new multiplication; sampled only in IDLE.
- multiplier  in  WIDTH  multiplier operand, latched on an accepted start.
- mcand_sh  in  WIDTH  shifted multiplicand from the left shifter. During iteration i it must equal (multiplicand << i) mod 2^WIDTH.
- shift  out  1  iteration with multiplier bit 0: shift only.
- add_shift  out  1  iteration with multiplier bit 1: add then shift.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when product is final.
- product  out  WIDTH  accumulator; final value held until the next accepted start.
- iter  out  $clog2(WIDTH)+1  current iteration index i.

Behaviour:
- Reset: synchronous and active-high; overrides everything, including mid-operation.
  - State -> IDLE.
  - acc, mreg and iter -> 0.
  - shift, add_shift, busy and done all 0; product = 0 from the cycle after the reset edge.
- Registers: mreg (WIDTH, remaining multiplier), acc (WIDTH), iter, 2-bit state {IDLE, RUN, DONE}.
- IDLE:
  - Outputs 0 except product = acc.
  - start=1 at edge k: mreg <= multiplier, acc <= 0, iter <= 0.
  - Next state is RUN. Exception: EARLY_EXIT=1 and multiplier==0 -> next state is DONE.
- RUN (busy=1):
  - Combinational: add_shift = mreg[0], shift = ~mreg[0]. Exactly one is high every RUN cycle.
  - At each edge:
    - acc <= acc + (mreg[0] ? mcand_sh : 0), truncated to WIDTH bits, carry discarded.
    - mreg <= mreg >> 1.
    - iter <= iter + 1.
  - Exit to DONE after the edge where iter==WIDTH-1.
  - Also exit to DONE when EARLY_EXIT=1 and (mreg>>1)==0.
  - start is ignored in RUN.
- DONE (one cycle):
  - done=1, busy=0, shift=add_shift=0, product = final acc.
  - Next state is always IDLE. start in the DONE cycle is ignored; a new start is taken in IDLE.
- Latency, with start accepted at edge k:
  - Iterations occupy cycles k+1 .. k+N.
  - done is high in cycle k+N+1.
  - N = WIDTH when EARLY_EXIT=0.
  - With EARLY_EXIT=1, N = index of the highest set multiplier bit + 1, or 0 for multiplier 0.
- product always equals acc and is stable from done until the edge that accepts the next start, which clears it.
- The block never stalls; mcand_sh is assumed valid every RUN cycle.

Test Plan:
- Basic multiply: WIDTH=32, EARLY_EXIT=1, start with multiplier=5, bench drives mcand_sh = 6<<iter. Required: add_shift,shift,add_shift over 3 RUN cycles, done at cycle k+4, product=30.
- Zero multiplier: multiplier=0, EARLY_EXIT=1. Required: no shift/add_shift, done at cycle k+1, product=0. With EARLY_EXIT=0: 32 shift cycles, then done, product=0.
- Overflow wrap: multiplicand=0xFFFFFFFF, multiplier=0xFFFFFFFF, mcand_sh = 0xFFFFFFFF<<iter. Required: 32 add_shift cycles, done at cycle k+33, product=0x00000001.
- Start while busy: start pulsed every cycle during a multiplier=0x80000000 run. Required: single continuous busy window of 32 cycles, exactly one done.
- Reset mid-operation: assert reset at iteration 10 of a 32-iteration run. Required: next cycle busy=0, done=0, product=0, state IDLE. A following start with 3×7 gives product=21.
- Back-to-back: start held high continuously, alternating multipliers 3 and 2 with multiplicand 9. Required: products 27 then 18, each with its own done pulse; each new run begins in the IDLE cycle after DONE.
